// File: rtl/axil_bram_pkg.sv
// Shared types and response codes for the AXI4-Lite to BRAM bridge.
package axil_bram_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        WR_RESP  = 3'd2,
        RD_ISSUE = 3'd3,
        RD_WAIT  = 3'd4,
        RD_DATA  = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_bram_bridge.sv
// AXI4-Lite slave driving port A of a BRAM with single-word accesses.
// One transaction in flight; reads and writes share the port round-robin.
// Optional build macro AXIL_BRAM_FULLWORD_ONLY_EN: partial-strobe writes are
// accepted but suppressed on the BRAM side and answered with SLVERR.
// READ_LATENCY must be 1..3 (matches the BRAM output register depth).
module axil_bram_bridge
    import axil_bram_pkg::*;
#(
    parameter int ADDR_WIDTH   = 13,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk_a,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [31:0]           s_wdata,
    input  logic [3:0]            s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [31:0]           bram_wrdata,
    output logic [3:0]            bram_we,
    input  logic [31:0]           bram_rddata
);

    localparam int CNT_W = 2;

    state_e                state_q, state_d;
    logic                  wr_last_q, wr_last_d;   // 1: last grant went to a write
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_err_q, wr_err_d;
    logic                  bram_en_q, bram_en_d;
    logic [3:0]            bram_we_q, bram_we_d;
    logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic [31:0]           bram_wrdata_q, bram_wrdata_d;
    logic                  s_bvalid_q, s_bvalid_d;
    logic [1:0]            s_bresp_q, s_bresp_d;
    logic                  s_rvalid_q, s_rvalid_d;
    logic [31:0]           s_rdata_q, s_rdata_d;

    logic wr_pend, rd_pend, grant_wr, grant_rd, in_idle, wr_reject;

    // The BRAM is word-addressed; the byte-lane bits of the AXI addresses are dropped.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

`ifdef AXIL_BRAM_FULLWORD_ONLY_EN
    assign wr_reject = (s_wstrb != 4'hF);
`else
    assign wr_reject = 1'b0;
`endif

    // Round-robin grant: a lone request wins, a tie goes to the class not served last.
    always_comb begin
        in_idle   = (state_q == IDLE) && !reset;
        wr_pend   = s_awvalid && s_wvalid;
        rd_pend   = s_arvalid;
        grant_wr  = in_idle && wr_pend && (!rd_pend || !wr_last_q);
        grant_rd  = in_idle && rd_pend && !grant_wr;
        s_awready = grant_wr;
        s_wready  = grant_wr;
        s_arready = grant_rd;
    end

    // Next-state and next-output computation for the transaction FSM.
    always_comb begin
        state_d       = state_q;
        wr_last_d     = wr_last_q;
        cnt_d         = cnt_q;
        wr_err_d      = wr_err_q;
        bram_en_d     = 1'b0;
        bram_we_d     = 4'h0;
        bram_addr_d   = bram_addr_q;
        bram_wrdata_d = bram_wrdata_q;
        s_bvalid_d    = s_bvalid_q;
        s_bresp_d     = s_bresp_q;
        s_rvalid_d    = s_rvalid_q;
        s_rdata_d     = s_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant_wr) begin
                    bram_en_d     = !wr_reject;
                    bram_we_d     = wr_reject ? 4'h0 : s_wstrb;
                    bram_addr_d   = {s_awaddr[ADDR_WIDTH-1:2], 2'b00};
                    bram_wrdata_d = s_wdata;
                    wr_err_d      = wr_reject;
                    wr_last_d     = 1'b1;
                    state_d       = WR_ISSUE;
                end else if (grant_rd) begin
                    bram_en_d   = 1'b1;
                    bram_addr_d = {s_araddr[ADDR_WIDTH-1:2], 2'b00};
                    wr_last_d   = 1'b0;
                    state_d     = RD_ISSUE;
                end
            end
            WR_ISSUE: begin
                s_bvalid_d = 1'b1;
                s_bresp_d  = wr_err_q ? RESP_SLVERR : RESP_OKAY;
                state_d    = WR_RESP;
            end
            WR_RESP: begin
                if (s_bready) begin
                    s_bvalid_d = 1'b0;
                    s_bresp_d  = RESP_OKAY;
                    state_d    = IDLE;
                end
            end
            RD_ISSUE: begin
                cnt_d   = CNT_W'(READ_LATENCY - 1);
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    s_rdata_d  = bram_rddata;
                    s_rvalid_d = 1'b1;
                    state_d    = RD_DATA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RD_DATA: begin
                if (s_rready) begin
                    s_rvalid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset drops any transaction without a response.
    always_ff @(posedge clk_a) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_last_q     <= 1'b0;
            cnt_q         <= '0;
            wr_err_q      <= 1'b0;
            bram_en_q     <= 1'b0;
            bram_we_q     <= 4'h0;
            bram_addr_q   <= '0;
            bram_wrdata_q <= '0;
            s_bvalid_q    <= 1'b0;
            s_bresp_q     <= RESP_OKAY;
            s_rvalid_q    <= 1'b0;
            s_rdata_q     <= '0;
        end else begin
            state_q       <= state_d;
            wr_last_q     <= wr_last_d;
            cnt_q         <= cnt_d;
            wr_err_q      <= wr_err_d;
            bram_en_q     <= bram_en_d;
            bram_we_q     <= bram_we_d;
            bram_addr_q   <= bram_addr_d;
            bram_wrdata_q <= bram_wrdata_d;
            s_bvalid_q    <= s_bvalid_d;
            s_bresp_q     <= s_bresp_d;
            s_rvalid_q    <= s_rvalid_d;
            s_rdata_q     <= s_rdata_d;
        end
    end

    assign bram_en     = bram_en_q;
    assign bram_we     = bram_we_q;
    assign bram_addr   = bram_addr_q;
    assign bram_wrdata = bram_wrdata_q;
    assign s_bvalid    = s_bvalid_q;
    assign s_bresp     = s_bresp_q;
    assign s_rvalid    = s_rvalid_q;
    assign s_rdata     = s_rdata_q;
    assign s_rresp     = RESP_OKAY;

endmodule

// File: tb/tb_axil_bram_bridge.sv
// Bench for axil_bram_bridge: a READ_LATENCY=1 instance with a RAM model and
// a READ_LATENCY=3 instance backed by a ROM pattern.
module tb_axil_bram_bridge;

    logic        clk_a = 1'b0;
    logic        reset = 1'b1;
    logic [12:0] s_awaddr = '0, s_araddr = '0;
    logic        s_awvalid = 0, s_wvalid = 0, s_arvalid = 0, s_bready = 0, s_rready = 0;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;
    logic        bram_en;
    logic [12:0] bram_addr;
    logic [31:0] bram_wrdata, bram_rddata;
    logic [3:0]  bram_we;

    logic        reset3 = 1'b1;
    logic [12:0] ar3addr = '0;
    logic        ar3valid = 0, r3ready = 0;
    logic        ar3ready, r3valid;
    logic [1:0]  r3resp;
    logic [31:0] r3data;
    logic        bram3_en;
    logic [12:0] bram3_addr;
    logic [31:0] bram3_wrdata, bram3_rddata;
    logic [3:0]  bram3_we;
    logic        unused_aw3ready, unused_w3ready, b3valid;
    logic [1:0]  unused_b3resp;
    logic [12:0] zero_addr = '0;
    logic [31:0] zero_data = '0;
    logic [3:0]  zero_strb = '0;
    logic        zero_bit = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 clk_a = ~clk_a;

    axil_bram_bridge #(.ADDR_WIDTH(13), .READ_LATENCY(1)) dut (
        .clk_a(clk_a), .reset(reset),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .bram_en(bram_en), .bram_addr(bram_addr), .bram_wrdata(bram_wrdata),
        .bram_we(bram_we), .bram_rddata(bram_rddata)
    );

    axil_bram_bridge #(.ADDR_WIDTH(13), .READ_LATENCY(3)) dut3 (
        .clk_a(clk_a), .reset(reset3),
        .s_awaddr(zero_addr), .s_awvalid(zero_bit), .s_awready(unused_aw3ready),
        .s_wdata(zero_data), .s_wstrb(zero_strb), .s_wvalid(zero_bit), .s_wready(unused_w3ready),
        .s_bresp(unused_b3resp), .s_bvalid(b3valid), .s_bready(zero_bit),
        .s_araddr(ar3addr), .s_arvalid(ar3valid), .s_arready(ar3ready),
        .s_rdata(r3data), .s_rresp(r3resp), .s_rvalid(r3valid), .s_rready(r3ready),
        .bram_en(bram3_en), .bram_addr(bram3_addr), .bram_wrdata(bram3_wrdata),
        .bram_we(bram3_we), .bram_rddata(bram3_rddata)
    );

    // RAM behind the latency-1 instance: one output register.
    logic [31:0] bmem [0:2047];
    logic [31:0] bpipe;
    always @(posedge clk_a) begin
        if (bram_en) begin
            for (int b = 0; b < 4; b++)
                if (bram_we[b]) bmem[bram_addr[12:2]][8*b +: 8] <= bram_wrdata[8*b +: 8];
            bpipe <= bmem[bram_addr[12:2]];
        end
    end
    assign bram_rddata = bpipe;

    // ROM behind the latency-3 instance: three output registers.
    function automatic logic [31:0] rom(input logic [10:0] idx);
        return {idx, 10'h2A5, ~idx};
    endfunction
    logic [31:0] p0, p1, p2;
    always @(posedge clk_a) begin
        p0 <= bram3_en ? rom(bram3_addr[12:2]) : p0;
        p1 <= p0;
        p2 <= p1;
    end
    assign bram3_rddata = p2;

    // Reference memory: what the PS should see after each accepted write.
    logic [31:0] ref_mem [0:2047];
    bit          wrote [0:2047];
    logic [10:0] wq [$];

    function automatic logic rejects(input logic [3:0] s);
`ifdef AXIL_BRAM_FULLWORD_ONLY_EN
        return s != 4'hF;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [10:0] idx;
        idx = a[12:2];
        if (rejects(s)) return;
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
        if (!wrote[idx]) begin
            wrote[idx] = 1'b1;
            wq.push_back(idx);
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s);
        int n;
        logic rej;
        rej = rejects(s);
        @(negedge clk_a);
        s_awaddr = a; s_wdata = d; s_wstrb = s; s_awvalid = 1; s_wvalid = 1; s_bready = 1;
        n = 0;
        #1;
        while (!s_awready && n < 20) begin @(negedge clk_a); #1; n++; end
        check("wr_awready", {31'b0, s_awready}, 1);
        check("wr_wready", {31'b0, s_wready}, 1);
        @(negedge clk_a);
        s_awvalid = 0; s_wvalid = 0;
        #1;
        check("wr_bram_en", {31'b0, bram_en}, {31'b0, !rej});
        check("wr_bram_we", {28'b0, bram_we}, rej ? 32'h0 : {28'b0, s});
        check("wr_bram_addr", {19'b0, bram_addr}, {19'b0, a[12:2], 2'b00});
        if (!rej) check("wr_bram_wrdata", bram_wrdata, d);
        check("wr_bvalid_early", {31'b0, s_bvalid}, 0);
        @(negedge clk_a);
        #1;
        check("wr_bvalid", {31'b0, s_bvalid}, 1);
        check("wr_bresp", {30'b0, s_bresp}, rej ? 32'h2 : 32'h0);
        model_write(a, d, s);
    endtask

    task automatic rd(input logic [12:0] a);
        int n;
        logic [31:0] exp;
        @(negedge clk_a);
        s_araddr = a; s_arvalid = 1; s_rready = 1;
        n = 0;
        #1;
        while (!s_arready && n < 20) begin @(negedge clk_a); #1; n++; end
        check("rd_arready", {31'b0, s_arready}, 1);
        exp = ref_mem[a[12:2]];
        @(negedge clk_a);
        s_arvalid = 0;
        #1;
        check("rd_bram_en", {31'b0, bram_en}, 1);
        check("rd_bram_we", {28'b0, bram_we}, 0);
        check("rd_bram_addr", {19'b0, bram_addr}, {19'b0, a[12:2], 2'b00});
        @(negedge clk_a);
        #1;
        check("rd_rvalid_early", {31'b0, s_rvalid}, 0);
        @(negedge clk_a);
        #1;
        check("rd_rvalid", {31'b0, s_rvalid}, 1);
        check("rd_rdata", s_rdata, exp);
        check("rd_rresp", {30'b0, s_rresp}, 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d1, d2, exp_rd, held;
        int inflight, grants, n;
        logic exp_w, seen;
        logic [12:0] a;
        logic [3:0] s;

        // ---------------- reset values, readies gated during reset
        repeat (3) @(negedge clk_a);
        ar3valid = 1;
        #1;
        check("rst_ar3ready", {31'b0, ar3ready}, 0);
        @(negedge clk_a);
        ar3valid = 0;
        reset = 0; reset3 = 0;
        #1;
        check("rst_bvalid", {31'b0, s_bvalid}, 0);
        check("rst_rvalid", {31'b0, s_rvalid}, 0);
        check("rst_bresp", {30'b0, s_bresp}, 0);
        check("rst_rdata", s_rdata, 0);
        check("rst_bram_en", {31'b0, bram_en}, 0);
        check("rst_bram_we", {28'b0, bram_we}, 0);
        check("rst_bram_addr", {19'b0, bram_addr}, 0);
        check("rst_bram_wrdata", bram_wrdata, 0);

        // ---------------- simultaneous arrival: W, R, W, R ...
        @(negedge clk_a);
        s_awaddr = 13'h40; s_araddr = 13'h40; s_wdata = $urandom; s_wstrb = 4'hF;
        s_awvalid = 1; s_wvalid = 1; s_arvalid = 1; s_bready = 1; s_rready = 1;
        exp_w = 1; inflight = 0; grants = 0; exp_rd = '0; n = 0;
        while (grants < 6 && n < 80) begin
            #1;
            if (s_bvalid) begin
                check("arb_bresp", {30'b0, s_bresp}, 0);
                inflight--;
            end
            if (s_rvalid) begin
                check("arb_rdata", s_rdata, exp_rd);
                inflight--;
            end
            if (s_awready || s_arready) begin
                check("arb_both_ready", {31'b0, s_awready && s_arready}, 0);
                check("arb_class", {31'b0, s_awready}, {31'b0, exp_w});
                check("arb_inflight", inflight, 0);
                if (s_awready) model_write(s_awaddr, s_wdata, s_wstrb);
                else exp_rd = ref_mem[s_araddr[12:2]];
                inflight++;
                grants++;
                exp_w = !exp_w;
            end
            @(negedge clk_a);
            n++;
            if (!s_awready) s_wdata = $urandom;
        end
        check("arb_grants", grants, 6);
        s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
        repeat (6) @(negedge clk_a);

        // ---------------- basic write then read
        wr(13'h0010, 32'hDEADBEEF, 4'hF);
        rd(13'h0010);

        // ---------------- unaligned last word
        wr(13'h1FFF, 32'hCAFEF00D, 4'hF);
        rd(13'h1FFC);

        // ---------------- partial strobe
        wr(13'h0020, 32'h11223344, 4'hF);
        wr(13'h0020, 32'hAABBCCDD, 4'h3);
        rd(13'h0020);

        // ---------------- backpressure on B then R
        d1 = $urandom; d2 = $urandom;
        @(negedge clk_a);
        s_awaddr = 13'h80; s_wdata = d1; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
        s_bready = 0; s_rready = 0; s_arvalid = 0;
        #1;
        check("bp_aw_accept", {31'b0, s_awready}, 1);
        model_write(13'h80, d1, 4'hF);
        @(negedge clk_a);
        s_awaddr = 13'h84; s_wdata = d2; s_araddr = 13'h80; s_arvalid = 1;
        @(negedge clk_a);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_bvalid_hold", {31'b0, s_bvalid}, 1);
            check("bp_awready_low", {31'b0, s_awready}, 0);
            check("bp_arready_low", {31'b0, s_arready}, 0);
            @(negedge clk_a);
        end
        s_bready = 1;
        #1;
        check("bp_bvalid_last", {31'b0, s_bvalid}, 1);
        @(negedge clk_a);
        s_bready = 0;
        #1;
        check("bp_ar_next_cycle", {31'b0, s_arready}, 1);
        check("bp_aw_lost_rr", {31'b0, s_awready}, 0);
        exp_rd = ref_mem[13'h80 >> 2];
        @(negedge clk_a);
        s_arvalid = 0;
        @(negedge clk_a);
        @(negedge clk_a);
        #1;
        held = s_rdata;
        check("bp_rdata", held, exp_rd);
        for (int i = 0; i < 5; i++) begin
            check("bp_rvalid_hold", {31'b0, s_rvalid}, 1);
            check("bp_rdata_stable", s_rdata, exp_rd);
            check("bp_awready_low_r", {31'b0, s_awready}, 0);
            @(negedge clk_a);
            #1;
        end
        s_rready = 1;
        #1;
        check("bp_rvalid_last", {31'b0, s_rvalid}, 1);
        @(negedge clk_a);
        s_bready = 1;
        #1;
        check("bp_aw_next_cycle", {31'b0, s_awready}, 1);
        model_write(13'h84, d2, 4'hF);
        @(negedge clk_a);
        s_awvalid = 0; s_wvalid = 0;
        repeat (3) @(negedge clk_a);
        rd(13'h84);

        // ---------------- randomized traffic
        for (int i = 0; i < 60; i++) begin
            if (wq.size() > 0 && ($urandom % 2 == 0)) begin
                a = {wq[$urandom % wq.size()], 2'(($urandom))};
                rd(a);
            end else begin
                a = 13'($urandom);
                s = (wrote[a[12:2]] && ($urandom % 3 == 0)) ? 4'($urandom_range(1, 14)) : 4'hF;
                wr(a, $urandom, s);
            end
        end

        // ---------------- latency-3 instance: normal read timing
        @(negedge clk_a);
        ar3addr = 13'h14; ar3valid = 1; r3ready = 1;
        #1;
        check("l3_arready", {31'b0, ar3ready}, 1);
        @(negedge clk_a);
        ar3valid = 0;
        #1;
        check("l3_bram_en", {31'b0, bram3_en}, 1);
        check("l3_bram_addr", {19'b0, bram3_addr}, 32'h14);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_a);
            #1;
            check("l3_rvalid_early", {31'b0, r3valid}, 0);
        end
        @(negedge clk_a);
        #1;
        check("l3_rvalid", {31'b0, r3valid}, 1);
        check("l3_rdata", r3data, rom(11'h5));

        // ---------------- reset during RD_WAIT
        @(negedge clk_a);
        ar3addr = 13'h20; ar3valid = 1;
        #1;
        check("l3r_arready", {31'b0, ar3ready}, 1);
        @(negedge clk_a);
        ar3valid = 0;
        @(negedge clk_a);
        reset3 = 1;
        @(negedge clk_a);
        reset3 = 0;
        #1;
        check("l3r_rvalid", {31'b0, r3valid}, 0);
        check("l3r_rdata", r3data, 0);
        check("l3r_rresp", {30'b0, r3resp}, 0);
        check("l3r_bvalid", {31'b0, b3valid}, 0);
        check("l3r_bram_en", {31'b0, bram3_en}, 0);
        check("l3r_bram_we", {28'b0, bram3_we}, 0);
        check("l3r_bram_addr", {19'b0, bram3_addr}, 0);
        check("l3r_bram_wrdata", bram3_wrdata, 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_a);
            #1;
            if (r3valid) seen = 1;
        end
        check("l3r_no_rvalid", {31'b0, seen}, 0);
        @(negedge clk_a);
        ar3addr = 13'h1FFC; ar3valid = 1;
        #1;
        check("l3n_arready", {31'b0, ar3ready}, 1);
        @(negedge clk_a);
        ar3valid = 0;
        repeat (3) @(negedge clk_a);
        #1;
        check("l3n_rvalid_early", {31'b0, r3valid}, 0);
        @(negedge clk_a);
        #1;
        check("l3n_rvalid", {31'b0, r3valid}, 1);
        check("l3n_rdata", r3data, rom(11'h7FF));
        @(negedge clk_a);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
